// File: rtl/mux_self_test_if.sv
// Bus between the mux self-tester and the mux under test / controlling host.
// master = self-tester side, slave = environment (host + DUT) side.
interface mux_self_test_if #(
   parameter int N_MUX = 8
);
   logic             start;
   logic             sel;
   logic             a;
   logic             b;
   logic [N_MUX-1:0] mux;
   logic             busy;
   logic             done;
   logic             pass;
   logic [7:0]       n_errors;
   logic [N_MUX+2:0] first_fail;

   modport master (
      input  start, mux,
      output sel, a, b, busy, done, pass, n_errors, first_fail
   );

   modport slave (
      output start, mux,
      input  sel, a, b, busy, done, pass, n_errors, first_fail
   );
endinterface

// File: rtl/mux_self_test.sv
// Built-in self test for a 2:1 mux bus: exhaustive {sel,a,b} sweep, optional
// LFSR random phase enabled by defining MUX_SELF_TEST_RANDOM_EN.

module mux_self_test_lane (
   input  logic resp,
   input  logic expect_bit,
   output logic miss
);
   assign miss = resp ^ expect_bit;
endmodule

module mux_self_test #(
   parameter int N_MUX          = 8,
   parameter int SETTLE_CYCLES  = 2,
   parameter int RANDOM_VECTORS = 8
) (
   input  logic           clk,
   input  logic           rst,
   mux_self_test_if.master bus
);

`ifdef MUX_SELF_TEST_RANDOM_EN
   localparam bit RANDOM_EN = 1'b1;
`else
   localparam bit RANDOM_EN = 1'b0;
`endif

   localparam int         TOTAL  = 8 + (RANDOM_EN ? RANDOM_VECTORS : 0);
   localparam logic [8:0] LAST   = 9'(TOTAL - 1);
   localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   state_t           state, state_nx;
   logic [2:0]       stim, stim_nx;
   logic [3:0]       cnt, cnt_nx;
   logic [8:0]       vec, vec_nx, vec_inc;
   logic [7:0]       nerr, nerr_nx;
   logic [N_MUX+2:0] ff, ff_nx;
   logic [N_MUX-1:0] mask;
   logic             expect_bit;

`ifdef MUX_SELF_TEST_RANDOM_EN
   logic [15:0] lfsr, lfsr_nx;
`endif

   // Reference value every lane of the bus must show for the current vector.
   assign expect_bit = stim[2] ? stim[1] : stim[0];

   for (genvar i = 0; i < N_MUX; i++) begin : g_lane
      mux_self_test_lane u_lane (
         .resp       (bus.mux[i]),
         .expect_bit (expect_bit),
         .miss       (mask[i])
      );
   end

   assign vec_inc = vec + 9'd1;

   always_comb begin
      state_nx = state;
      stim_nx  = stim;
      cnt_nx   = cnt;
      vec_nx   = vec;
      nerr_nx  = nerr;
      ff_nx    = ff;
`ifdef MUX_SELF_TEST_RANDOM_EN
      lfsr_nx  = lfsr;
`endif
      unique case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               stim_nx  = 3'b000;
               cnt_nx   = RELOAD;
               vec_nx   = '0;
               nerr_nx  = '0;
               ff_nx    = '0;
               state_nx = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == 4'd0) state_nx = CHECK;
            else             cnt_nx   = cnt - 4'd1;
         end
         CHECK: begin
            // One failing vector counts once; only the first one is recorded.
            if (|mask) begin
               if (nerr == 8'd0)  ff_nx   = {stim, mask};
               if (nerr != 8'hFF) nerr_nx = nerr + 8'd1;
            end
            if (vec == LAST) begin
               state_nx = DONE;
            end else begin
               vec_nx   = vec_inc;
               cnt_nx   = RELOAD;
               state_nx = SETTLE;
`ifdef MUX_SELF_TEST_RANDOM_EN
               if (vec_inc < 9'd8) begin
                  stim_nx = vec_inc[2:0];
               end else begin
                  stim_nx = lfsr[2:0];
                  lfsr_nx = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
               end
`else
               stim_nx = vec_inc[2:0];
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         stim  <= '0;
         cnt   <= '0;
         vec   <= '0;
         nerr  <= '0;
         ff    <= '0;
      end else begin
         state <= state_nx;
         stim  <= stim_nx;
         cnt   <= cnt_nx;
         vec   <= vec_nx;
         nerr  <= nerr_nx;
         ff    <= ff_nx;
      end
   end

`ifdef MUX_SELF_TEST_RANDOM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= lfsr_nx;
   end
`endif

   assign bus.sel        = stim[2];
   assign bus.a          = stim[1];
   assign bus.b          = stim[0];
   assign bus.busy       = (state == SETTLE) || (state == CHECK);
   assign bus.done       = (state == DONE);
   assign bus.pass       = (state == DONE) && (nerr == 8'd0);
   assign bus.n_errors   = nerr;
   assign bus.first_fail = ff;

endmodule

// File: tb/tb_mux_self_test.sv
// Bench for mux_self_test: run-level model checked every cycle, plus
// directed scenarios with hand-computed results.
module tb_mux_self_test;
   localparam int N_MUX  = 8;
   localparam int SETTLE = 2;
   localparam int RV     = 8;
   localparam int P      = SETTLE + 1;
`ifdef MUX_SELF_TEST_RANDOM_EN
   localparam int RV_M = RV;
`else
   localparam int RV_M = 0;
`endif
   localparam int T       = 8 + RV_M;
   localparam int DONE_AT = T * P;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   mode = 0;   // 0 ideal, 1 bit5 stuck at 1, 2 sel inverted
   int   tests = 0;
   int   fails = 0;

   mux_self_test_if #(.N_MUX(N_MUX)) bus ();

   mux_self_test #(.N_MUX(N_MUX), .SETTLE_CYCLES(SETTLE), .RANDOM_VECTORS(RV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] resp(input int md, input logic [2:0] v);
      logic good;
      good = v[2] ? v[1] : v[0];
      case (md)
         1:       return {8{good}} | 8'h20;
         2:       return {8{v[2] ? v[0] : v[1]}};
         default: return {8{good}};
      endcase
   endfunction

   assign bus.mux = resp(mode, {bus.sel, bus.a, bus.b});

   function automatic logic [15:0] adv(input logic [15:0] l, input int n);
      for (int k = 0; k < n; k++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      return l;
   endfunction

   function automatic logic [2:0] vec_at(input int j, input logic [15:0] seed);
      logic [15:0] l;
      if (j < 8) return 3'(j);
      l = adv(seed, j - 8);
      return l[2:0];
   endfunction

   // Outcome after the first n vectors of a run have been judged.
   function automatic void score(input int n, input logic [15:0] seed, input int md,
                                 output logic [7:0] en, output logic [10:0] ef);
      logic [2:0] v;
      logic [7:0] m;
      en = 0;
      ef = 0;
      for (int j = 0; j < n; j++) begin
         v = vec_at(j, seed);
         m = resp(md, v) ^ {8{v[2] ? v[1] : v[0]}};
         if (m != 0) begin
            if (en == 0) ef = {v, m};
            if (en != 8'hFF) en = en + 1;
         end
      end
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Run-level model: where in the run we are, and which vector list applies.
   typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;
   mst_t        m_st   = M_IDLE;
   int          m_cyc  = 0;
   int          m_mode = 0;
   logic [15:0] m_seed = 16'hACE1;
   logic [15:0] m_lfsr = 16'hACE1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st   <= M_IDLE;
         m_cyc  <= 0;
         m_lfsr <= 16'hACE1;
         m_seed <= 16'hACE1;
      end else if (m_st != M_RUN && bus.start) begin
         m_st   <= M_RUN;
         m_cyc  <= 0;
         m_mode <= mode;
         m_seed <= m_lfsr;
         m_lfsr <= adv(m_lfsr, RV_M);
      end else if (m_st == M_RUN) begin
         m_cyc <= m_cyc + 1;
         if (m_cyc + 1 == DONE_AT) m_st <= M_DONE;
      end
   end

   always @(negedge clk) begin : cmp
      logic [2:0]  ev;
      logic [7:0]  en;
      logic [10:0] ef;
      logic [24:0] act;
      if (!rst) begin
         act = {bus.sel, bus.a, bus.b, bus.busy, bus.done, bus.pass, bus.n_errors, bus.first_fail};
         case (m_st)
            M_IDLE: check("idle_outputs", act, 25'd0);
            M_RUN: begin
               ev = vec_at(m_cyc / P, m_seed);
               score(m_cyc / P, m_seed, m_mode, en, ef);
               check("run_outputs", act, {ev, 1'b1, 1'b0, 1'b0, en, ef});
            end
            default: begin
               ev = vec_at(T - 1, m_seed);
               score(T, m_seed, m_mode, en, ef);
               check("done_outputs", act, {ev, 1'b0, 1'b1, en == 0, en, ef});
            end
         endcase
      end
   end

   // Starts a run in fault mode md; start is re-raised at run cycles p1/p2.
   task automatic run(input int md, input int p1, input int p2, output int cyc, output logic [2:0] r0);
      @(posedge clk); #1;
      mode = md;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 0;
      r0  = 3'b000;
      while (!bus.done && cyc < DONE_AT + 20) begin
         if (cyc == 8 * P) r0 = {bus.sel, bus.a, bus.b};
         bus.start = (cyc == p1) || (cyc == p2);
         @(posedge clk); #1;
         cyc++;
      end
      bus.start = 1'b0;
      check("run_reaches_done", bus.done, 1'b1);
   endtask

   initial begin
      int         cyc;
      logic [2:0] r0;
      int         seen;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_nerr", bus.n_errors, 8'd0);
      check("rst_ff", bus.first_fail, 11'd0);
      check("rst_stim", {bus.sel, bus.a, bus.b}, 3'b000);
      rst = 1'b0;

      run(0, -1, -1, cyc, r0);
`ifdef MUX_SELF_TEST_RANDOM_EN
      check("ideal_done_at", cyc, 48);
      check("first_random_vec", r0, 3'b001);
`else
      check("ideal_done_at", cyc, 24);
`endif
      check("ideal_pass", bus.pass, 1'b1);
      check("ideal_nerr", bus.n_errors, 8'd0);
      check("ideal_ff", bus.first_fail, 11'd0);

`ifndef MUX_SELF_TEST_RANDOM_EN
      // Bit 5 stuck at 1 breaks every vector whose selected input is 0:
      // 000, 010 (sel=0 picks b=0), 100 and 101.
      run(1, -1, -1, cyc, r0);
      check("stuck5_nerr", bus.n_errors, 8'd4);
      check("stuck5_ff", bus.first_fail, 11'h020);
      check("stuck5_pass", bus.pass, 1'b0);

      run(2, -1, -1, cyc, r0);
      check("selinv_nerr", bus.n_errors, 8'd4);
      check("selinv_ff", bus.first_fail, 11'h1FF);
      check("selinv_pass", bus.pass, 1'b0);

      // Restart straight out of DONE clears the previous failures.
      run(0, -1, -1, cyc, r0);
      check("restart_done_at", cyc, 24);
      check("restart_nerr", bus.n_errors, 8'd0);
      check("restart_pass", bus.pass, 1'b1);

      run(0, 5, 12, cyc, r0);
      check("busy_start_done_at", cyc, 24);
`endif

      // Start coinciding with the final CHECK edge must not restart.
      run(0, DONE_AT - 1, -1, cyc, r0);
      check("final_check_start_done_at", cyc, DONE_AT);
      repeat (3) @(posedge clk);
      #1;
      check("done_held", {bus.done, bus.busy}, 2'b10);

      // Abort mid-run with reset.
      @(posedge clk); #1;
      mode = 0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_busy", bus.busy, 1'b0);
      check("abort_done", bus.done, 1'b0);
      check("abort_stim", {bus.sel, bus.a, bus.b}, 3'b000);
      check("abort_nerr", bus.n_errors, 8'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (DONE_AT + 6) begin
         @(posedge clk); #1;
         if (bus.done) seen = 1;
      end
      check("abort_no_done", seen, 0);
      run(0, -1, -1, cyc, r0);
      check("after_abort_done_at", cyc, DONE_AT);
      check("after_abort_pass", bus.pass, 1'b1);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
